id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS core. It latches decoded ID-stage fields and drives the EX forwarding unit (op, Rs, Rt, wb) and the ALU datapath.
- It also owns hazard detection: the load-use hazard, plus the branch-in-ID hazard that the ID-stage forwarding paths (EX/MEM, MEM/WB only) cannot cover.
- It produces the stall signal for the PC and IF/ID, and inserts bubbles itself.

Parameters:
- DATA_W, 32, width of register-file operands and sign-extended immediate.
- BCNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  external freeze; hold all state
- flush_i  in  1  squash the ID instruction; load a bubble
- id_op  in  6  opcode in ID
- id_rs  in  5  Rs field in ID
- id_rt  in  5  Rt field in ID
- id_rd  in  5  Rd field in ID
- id_wb  in  2  [1]=RegWrite, [0]=MemtoReg
- id_m  in  2  [1]=MemRead, [0]=MemWrite
- id_ex  in  5  [4]=RegDst, [3]=ALUSrc, [2:0]=ALUOp
- id_is_branch  in  1  instruction in ID is beq/bne (compared in ID)
- id_rdata1  in  DATA_W  register-file port A
- id_rdata2  in  DATA_W  register-file port B
- id_imm  in  DATA_W  sign-extended immediate
- ex_mem_memread  in  1  MemRead of the instruction in EX/MEM
- ex_mem_rd  in  5  destination register of the instruction in EX/MEM
- ID_EX_op  out  6  registered opcode
- ID_EX_Rs  out  5  registered Rs
- ID_EX_Rt  out  5  registered Rt
- ID_EX_Rd  out  5  registered Rd
- ID_EX_wb  out  2  registered wb
- ID_EX_m  out  2  registered m
- ID_EX_ex  out  5  registered ex controls
- ID_EX_rdata1  out  DATA_W  registered operand A
- ID_EX_rdata2  out  DATA_W  registered operand B
- ID_EX_imm  out  DATA_W  registered immediate
- ID_EX_valid  out  1  1 = real instruction; 0 = bubble
- hazard_stall  out  1  combinational; freezes the PC and IF/ID
- bubble_cnt  out  BCNT_W  count of bubbles inserted

Behaviour:
- Reset (rst_n=0, asynchronous): all ID_EX_* outputs are 0, ID_EX_valid=0, bubble_cnt=0. hazard_stall evaluates to 0 because valid=0 and wb/m are 0.
- Destination register: ex_dst = ID_EX_ex[4] ? ID_EX_Rd : ID_EX_Rt.
- load_use = ID_EX_valid & ID_EX_m[1] & (ID_EX_Rt!=0) & (ID_EX_Rt==id_rs | ID_EX_Rt==id_rt).
- br_ex = id_is_branch & ID_EX_valid & ID_EX_wb[1] & (ex_dst!=0) & (ex_dst==id_rs | ex_dst==id_rt).
- br_mem = id_is_branch & ex_mem_memread & (ex_mem_rd!=0) & (ex_mem_rd==id_rs | ex_mem_rd==id_rt).
- hazard_stall = (load_use | br_ex | br_mem) & ~flush_i. No registered latency: it depends on current ID inputs and current ID/EX state.
- Register update on each rising clk edge, in priority order:
  1. flush_i=1: load a bubble.
  2. stall_i=1: hold every register, including bubble_cnt.
  3. hazard_stall=1: load a bubble.
  4. Otherwise: capture all id_* fields and set valid=1.
- Bubble contents: op, Rs, Rt, Rd, wb, m, ex all 0 and valid=0. Zeroed Rs/Rt mean the forwarding units never match a bubble. rdata1, rdata2 and imm are also 0.
- Latency: an instruction present in ID at edge N appears on ID_EX_* after edge N, unless stalled or bubbled.
- Load-use sequence: exactly 1 bubble. The next cycle the load is in EX/MEM, so load_use clears and EX forwarding covers the dependency from MEM/WB.
- Branch after an ALU producer: 1 bubble (br_ex, then br_mem=0).
- Branch after a load: 2 bubbles (br_ex, then br_mem).
- bubble_cnt increments by 1 on each bubble loaded by priority 1 or 3. It saturates at all-ones and never wraps.
- Simultaneous flush_i and stall_i: the flush wins and a bubble is loaded.
- Simultaneous stall_i and hazard_stall: hold; no bubble is counted.
- rst_n asserted mid-stall: outputs clear immediately. After release, normal loading resumes on the first edge.

Test Plan:
- Reset: rst_n=0 with random id_* and a clock running -> all outputs 0, hazard_stall=0. Release, feed add $3,$1,$2 -> after 1 edge ID_EX_Rd=3, ID_EX_wb=2'b10, valid=1.
- Load-use: lw $2,0($1) registered (m=2'b10, Rt=2), then ID holds add $4,$2,$5 -> hazard_stall=1. Next edge: bubble (wb=0, Rs=0, valid=0), bubble_cnt=1. Following edge: the add is captured and hazard_stall=0.
- Branch after load: lw $2 in ID/EX, then beq $2,$0 in ID -> hazard_stall=1 for 2 cycles (br_ex, then br_mem with ex_mem_memread=1, ex_mem_rd=2); bubble_cnt +2. Branch after addi $2 -> 1 cycle only.
- $0 destination: lw $0 in ID/EX, add using $0 in ID -> hazard_stall=0, no bubble.
- Priority: flush_i=1 with stall_i=1 -> bubble, bubble_cnt+1. stall_i=1 with load_use active -> registers unchanged, bubble_cnt unchanged.
- Saturation/reset: preload bubble_cnt to 16'hFFFF via repeated flushes -> stays at FFFF. Assert rst_n=0 mid-cycle -> counter and outputs are 0 before the next edge.

Source files
------------

// File: rtl/id_ex_pipe_reg_if.sv
// ID-stage bundle feeding the ID/EX register: decoded fields, controls and operands.
// The ID stage drives it through the master modport; the ID/EX register consumes it through the slave modport.
interface id_ex_pipe_reg_if #(
  parameter int DATA_W = 32
);
  logic [5:0]        id_op;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic [1:0]        id_wb;
  logic [1:0]        id_m;
  logic [4:0]        id_ex;
  logic              id_is_branch;
  logic [DATA_W-1:0] id_rdata1;
  logic [DATA_W-1:0] id_rdata2;
  logic [DATA_W-1:0] id_imm;

  modport master (
    output id_op, id_rs, id_rt, id_rd, id_wb, id_m, id_ex,
           id_is_branch, id_rdata1, id_rdata2, id_imm
  );

  modport slave (
    input id_op, id_rs, id_rt, id_rd, id_wb, id_m, id_ex,
          id_is_branch, id_rdata1, id_rdata2, id_imm
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use and branch-in-ID hazard detection.
// The register inserts its own bubbles and raises hazard_stall to freeze the PC and IF/ID.
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int BCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  id_ex_pipe_reg_if.slave   id_bus,
  input  logic              ex_mem_memread,
  input  logic [4:0]        ex_mem_rd,
  output logic [5:0]        ID_EX_op,
  output logic [4:0]        ID_EX_Rs,
  output logic [4:0]        ID_EX_Rt,
  output logic [4:0]        ID_EX_Rd,
  output logic [1:0]        ID_EX_wb,
  output logic [1:0]        ID_EX_m,
  output logic [4:0]        ID_EX_ex,
  output logic [DATA_W-1:0] ID_EX_rdata1,
  output logic [DATA_W-1:0] ID_EX_rdata2,
  output logic [DATA_W-1:0] ID_EX_imm,
  output logic              ID_EX_valid,
  output logic              hazard_stall,
  output logic [BCNT_W-1:0] bubble_cnt
);

  logic [5:0]        op_q, op_d;
  logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [1:0]        wb_q, wb_d, m_q, m_d;
  logic [4:0]        ex_q, ex_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d, imm_q, imm_d;
  logic              valid_q, valid_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;

  logic [4:0] ex_dst;
  logic       load_use, br_ex, br_mem;
  logic       load_bubble, capture;

  always_comb begin
    ex_dst   = ex_q[4] ? rd_q : rt_q;
    load_use = valid_q & m_q[1] & (rt_q != 5'd0) &
               ((rt_q == id_bus.id_rs) | (rt_q == id_bus.id_rt));
    br_ex    = id_bus.id_is_branch & valid_q & wb_q[1] & (ex_dst != 5'd0) &
               ((ex_dst == id_bus.id_rs) | (ex_dst == id_bus.id_rt));
    // The ID-stage comparator cannot see a load result still in EX/MEM.
    br_mem   = id_bus.id_is_branch & ex_mem_memread & (ex_mem_rd != 5'd0) &
               ((ex_mem_rd == id_bus.id_rs) | (ex_mem_rd == id_bus.id_rt));
    hazard_stall = (load_use | br_ex | br_mem) & ~flush_i;

    load_bubble = flush_i | (~stall_i & hazard_stall);
    capture     = ~flush_i & ~stall_i & ~hazard_stall;

    op_d     = op_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    wb_d     = wb_q;
    m_d      = m_q;
    ex_d     = ex_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    imm_d    = imm_q;
    valid_d  = valid_q;
    bcnt_d   = bcnt_q;

    if (load_bubble) begin
      op_d     = '0;
      rs_d     = '0;
      rt_d     = '0;
      rd_d     = '0;
      wb_d     = '0;
      m_d      = '0;
      ex_d     = '0;
      rdata1_d = '0;
      rdata2_d = '0;
      imm_d    = '0;
      valid_d  = 1'b0;
      if (bcnt_q != {BCNT_W{1'b1}}) begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end else if (capture) begin
      op_d     = id_bus.id_op;
      rs_d     = id_bus.id_rs;
      rt_d     = id_bus.id_rt;
      rd_d     = id_bus.id_rd;
      wb_d     = id_bus.id_wb;
      m_d      = id_bus.id_m;
      ex_d     = id_bus.id_ex;
      rdata1_d = id_bus.id_rdata1;
      rdata2_d = id_bus.id_rdata2;
      imm_d    = id_bus.id_imm;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      wb_q     <= '0;
      m_q      <= '0;
      ex_q     <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      valid_q  <= 1'b0;
      bcnt_q   <= '0;
    end else begin
      op_q     <= op_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      wb_q     <= wb_d;
      m_q      <= m_d;
      ex_q     <= ex_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q    <= imm_d;
      valid_q  <= valid_d;
      bcnt_q   <= bcnt_d;
    end
  end

  assign ID_EX_op     = op_q;
  assign ID_EX_Rs     = rs_q;
  assign ID_EX_Rt     = rt_q;
  assign ID_EX_Rd     = rd_q;
  assign ID_EX_wb     = wb_q;
  assign ID_EX_m      = m_q;
  assign ID_EX_ex     = ex_q;
  assign ID_EX_rdata1 = rdata1_q;
  assign ID_EX_rdata2 = rdata2_q;
  assign ID_EX_imm    = imm_q;
  assign ID_EX_valid  = valid_q;
  assign bubble_cnt   = bcnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: expected ID/EX contents are queued when an
// instruction is driven and compared after the capturing edge.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [1:0]  wb;
    logic [1:0]  m;
    logic [4:0]  ex;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic        valid;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        ex_mem_memread = 1'b0;
  logic [4:0]  ex_mem_rd = 5'd0;
  logic [5:0]  ID_EX_op;
  logic [4:0]  ID_EX_Rs, ID_EX_Rt, ID_EX_Rd;
  logic [1:0]  ID_EX_wb, ID_EX_m;
  logic [4:0]  ID_EX_ex;
  logic [31:0] ID_EX_rdata1, ID_EX_rdata2, ID_EX_imm;
  logic        ID_EX_valid;
  logic        hazard_stall;
  logic [15:0] bubble_cnt;

  int compared = 0;
  int mismatched = 0;
  exp_t cur;
  exp_t sb[$];

  id_ex_pipe_reg_if #(.DATA_W(32)) idb ();

  id_ex_pipe_reg #(.DATA_W(32), .BCNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .id_bus         (idb),
    .ex_mem_memread (ex_mem_memread),
    .ex_mem_rd      (ex_mem_rd),
    .ID_EX_op       (ID_EX_op),
    .ID_EX_Rs       (ID_EX_Rs),
    .ID_EX_Rt       (ID_EX_Rt),
    .ID_EX_Rd       (ID_EX_Rd),
    .ID_EX_wb       (ID_EX_wb),
    .ID_EX_m        (ID_EX_m),
    .ID_EX_ex       (ID_EX_ex),
    .ID_EX_rdata1   (ID_EX_rdata1),
    .ID_EX_rdata2   (ID_EX_rdata2),
    .ID_EX_imm      (ID_EX_imm),
    .ID_EX_valid    (ID_EX_valid),
    .hazard_stall   (hazard_stall),
    .bubble_cnt     (bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t observed();
    exp_t o;
    o.op = ID_EX_op;   o.rs = ID_EX_Rs;   o.rt = ID_EX_Rt;   o.rd = ID_EX_Rd;
    o.wb = ID_EX_wb;   o.m = ID_EX_m;     o.ex = ID_EX_ex;
    o.r1 = ID_EX_rdata1; o.r2 = ID_EX_rdata2; o.imm = ID_EX_imm;
    o.valid = ID_EX_valid; o.cnt = bubble_cnt;
    return o;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  function automatic exp_t bubble_of(input exp_t prev);
    exp_t b;
    b = '0;
    b.cnt = sat_inc(prev.cnt);
    return b;
  endfunction

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [1:0] wb, input logic [1:0] m,
                        input logic [4:0] ex, input logic br);
    idb.id_op = op; idb.id_rs = rs; idb.id_rt = rt; idb.id_rd = rd;
    idb.id_wb = wb; idb.id_m = m; idb.id_ex = ex; idb.id_is_branch = br;
    idb.id_rdata1 = $urandom; idb.id_rdata2 = $urandom; idb.id_imm = $urandom;
  endtask

  // Check the combinational hazard, queue the expected ID/EX state, clock, compare.
  task automatic step(input string tag, input logic exp_haz);
    exp_t e;
    exp_t o;
    #1;
    check({tag, ":haz"}, {159'd0, hazard_stall}, {159'd0, exp_haz});
    if (flush_i) e = bubble_of(cur);
    else if (stall_i) e = cur;
    else if (exp_haz) e = bubble_of(cur);
    else begin
      e.op = idb.id_op; e.rs = idb.id_rs; e.rt = idb.id_rt; e.rd = idb.id_rd;
      e.wb = idb.id_wb; e.m = idb.id_m; e.ex = idb.id_ex;
      e.r1 = idb.id_rdata1; e.r2 = idb.id_rdata2; e.imm = idb.id_imm;
      e.valid = 1'b1; e.cnt = cur.cnt;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    o = observed();
    check(tag, {17'd0, o}, {17'd0, e});
    cur = e;
    $display("step %-12s haz=%0b valid=%0b rd=%0d cnt=%0d", tag, exp_haz, o.valid, o.rd, o.cnt);
  endtask

  initial begin
    cur = '0;
    set_id(6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           2'($urandom), 2'($urandom), 5'($urandom), 1'($urandom));
    repeat (3) @(posedge clk);
    #1;
    check("reset_regs", {17'd0, observed()}, 160'd0);
    check("reset_haz", {159'd0, hazard_stall}, 160'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // add $3,$1,$2
    set_id(6'h00, 5'd1, 5'd2, 5'd3, 2'b10, 2'b00, 5'b10010, 1'b0);
    step("add3", 1'b0);
    // lw $2,0($1) then dependent add $4,$2,$5: one bubble
    set_id(6'h23, 5'd1, 5'd2, 5'd0, 2'b11, 2'b10, 5'b01000, 1'b0);
    step("lw2", 1'b0);
    set_id(6'h00, 5'd2, 5'd5, 5'd4, 2'b10, 2'b00, 5'b10010, 1'b0);
    step("lu_bubble", 1'b1);
    step("lu_add", 1'b0);

    // beq after lw: two bubbles (EX then EX/MEM load)
    set_id(6'h23, 5'd1, 5'd2, 5'd0, 2'b11, 2'b10, 5'b01000, 1'b0);
    step("lw2b", 1'b0);
    set_id(6'h04, 5'd2, 5'd0, 5'd0, 2'b00, 2'b00, 5'b00001, 1'b1);
    step("brld_ex", 1'b1);
    ex_mem_memread = 1'b1; ex_mem_rd = 5'd2;
    step("brld_mem", 1'b1);
    ex_mem_memread = 1'b0; ex_mem_rd = 5'd0;
    step("brld_go", 1'b0);

    // beq after addi: one bubble
    set_id(6'h08, 5'd1, 5'd2, 5'd0, 2'b10, 2'b00, 5'b01000, 1'b0);
    step("addi2", 1'b0);
    set_id(6'h04, 5'd2, 5'd0, 5'd0, 2'b00, 2'b00, 5'b00001, 1'b1);
    step("bralu_ex", 1'b1);
    ex_mem_rd = 5'd2;
    step("bralu_go", 1'b0);
    ex_mem_rd = 5'd0;

    // $0 destination never creates a hazard
    set_id(6'h23, 5'd1, 5'd0, 5'd0, 2'b11, 2'b10, 5'b01000, 1'b0);
    step("lw0", 1'b0);
    set_id(6'h00, 5'd0, 5'd0, 5'd5, 2'b10, 2'b00, 5'b10010, 1'b0);
    step("add_r0", 1'b0);

    // Priority: stall beats hazard; flush beats stall
    set_id(6'h23, 5'd1, 5'd2, 5'd0, 2'b11, 2'b10, 5'b01000, 1'b0);
    step("lw2c", 1'b0);
    set_id(6'h00, 5'd2, 5'd5, 5'd4, 2'b10, 2'b00, 5'b10010, 1'b0);
    stall_i = 1'b1;
    step("stall_hold", 1'b1);
    flush_i = 1'b1;
    step("flush_stall", 1'b0);
    stall_i = 1'b0; flush_i = 1'b0;
    step("after_flush", 1'b0);

    // Saturation: unchecked flush run up to FFFD, then checked steps across the limit
    flush_i = 1'b1;
    repeat (65533 - int'(cur.cnt)) @(posedge clk);
    #1;
    cur = '0;
    cur.cnt = 16'hFFFD;
    step("sat_fffe", 1'b0);
    step("sat_ffff", 1'b0);
    step("sat_hold", 1'b0);
    flush_i = 1'b0;

    // Asynchronous reset while stalled clears before the next edge
    set_id(6'h00, 5'd1, 5'd2, 5'd3, 2'b10, 2'b00, 5'b10010, 1'b0);
    step("pre_rst", 1'b0);
    stall_i = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_midstall", {17'd0, observed()}, 160'd0);
    cur = '0;
    #2;
    rst_n = 1'b1;
    stall_i = 1'b0;
    set_id(6'h00, 5'd6, 5'd7, 5'd8, 2'b10, 2'b00, 5'b10010, 1'b0);
    step("post_rst", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
